io_port: RTL and testbench

Memory-mapped I/O peripheral on the CPU's I/O space, downstream of the core's bus outputs.
- **Input side:** decodes the CPU's address, write-data, write-enable and I/O-select strobes, and drives the value the core loads on an I/O read.
- **Output side:** queues CPU writes in a small TX FIFO that drains to an external valid/ready sink.
- **Receive side:** captures one word from an external valid/ready source in an RX holding register.

---
 rtl/io_port_if.sv | 30 +++
 rtl/io_port.sv | 165 ++++++++++++++++
 tb/tb_io_port.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_if.sv
// io_port_if: bundle of the CPU I/O bus and the TX/RX valid/ready streams
// that connect to io_port.
//   CPU side : a_in, d_in, wen_in, iom_in in; io_out out (combinational read data)
//   TX stream: tx_data_out, tx_valid_out out; tx_ready_in in
//   RX stream: rx_data_in, rx_valid_in in; rx_ready_out out
// The slave modport is the peripheral's view. The master modport is the view
// of whatever drives the bus and the streams (CPU plus external sink/source).
interface io_port_if;
    logic [15:0] a_in;
    logic [15:0] d_in;
    logic        wen_in;
    logic        iom_in;
    logic [15:0] io_out;
    logic [15:0] tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic [15:0] rx_data_in;
    logic        rx_valid_in;
    logic        rx_ready_out;

    modport slave (
        input  a_in, d_in, wen_in, iom_in, tx_ready_in, rx_data_in, rx_valid_in,
        output io_out, tx_data_out, tx_valid_out, rx_ready_out
    );

    modport master (
        output a_in, d_in, wen_in, iom_in, tx_ready_in, rx_data_in, rx_valid_in,
        input  io_out, tx_data_out, tx_valid_out, rx_ready_out
    );
endinterface

// File: rtl/io_port.sv
// io_port: memory-mapped I/O peripheral in the CPU's I/O space.
// CPU writes to TXDATA are queued in a DEPTH-entry TX FIFO that drains to a
// valid/ready sink. One word from a valid/ready source is held in an RX
// register until the CPU acknowledges it. A loopback mode routes the TX head
// straight into the RX register.
// Ports:
//   clk - single clock, rising edge
//   rst - synchronous, active-high reset
//   bus - io_port_if.slave: CPU address/data/strobes and read data, TX and RX streams
// Register map (offset a_in[1:0]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
module io_port #(
    parameter logic [15:0] BASE  = 16'hFF00,
    parameter int          DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    io_port_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    // Address decode and write strobe
    logic             hit;
    logic             wr;
    logic [1:0]       off;
    logic             wr_p1;
    logic [1:0]       off_p1;
    logic             new_wr;

    // TX FIFO
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              tx_empty;
    logic              tx_full;
    logic [DATA_W-1:0] tx_head;
    logic              push_req;
    logic              push;
    logic              pop_ext;
    logic              pop_loop;
    logic              pop;

    // Status / control / RX
    logic              tx_ovf;
    logic              tx_en;
    logic              loop;
    logic              rx_full;
    logic [DATA_W-1:0] rx_reg;
    logic              rx_cap_ext;
    logic              rx_load;
    logic [DATA_W-1:0] rx_load_data;
    logic              ack;
    logic              stat_wr;
    logic              ctrl_wr;
    logic [DATA_W-1:0] status;

    assign hit = bus.iom_in && (bus.a_in[15:2] == BASE[15:2]);
    assign wr  = hit && bus.wen_in;
    assign off = bus.a_in[1:0];

    // A held strobe acts once; moving to another register while the strobe
    // stays high counts as a fresh write.
    assign new_wr = wr && (!wr_p1 || (off != off_p1));

    assign push_req = new_wr && (off == 2'd0);
    assign ack      = new_wr && (off == 2'd1);
    assign stat_wr  = new_wr && (off == 2'd2);
    assign ctrl_wr  = new_wr && (off == 2'd3);

    assign tx_empty = (count == '0);
    assign tx_full  = (count == CNT_W'(DEPTH));
    assign tx_head  = mem[rd_ptr];

    // Full is judged before any pop in the same cycle, so a push into a full
    // FIFO is always dropped.
    assign push = push_req && !tx_full;

    assign bus.tx_valid_out = !tx_empty && tx_en && !loop;
    assign bus.tx_data_out  = tx_empty ? '0 : tx_head;
    assign pop_ext          = bus.tx_valid_out && bus.tx_ready_in;
    assign pop_loop         = loop && tx_en && !tx_empty && !rx_full;
    assign pop              = pop_ext || pop_loop;

    assign bus.rx_ready_out = !loop && !rx_full && !rst;
    assign rx_cap_ext       = bus.rx_valid_in && bus.rx_ready_out;
    assign rx_load          = pop_loop || rx_cap_ext;
    assign rx_load_data     = pop_loop ? tx_head : bus.rx_data_in;

    always_comb begin
        status      = '0;
        status[3:0] = 4'(count);
        status[4]   = tx_empty;
        status[5]   = tx_full;
        status[6]   = rx_full;
        status[7]   = tx_ovf;
        status[8]   = tx_en;
    end

    // Zero-latency read mux; reads have no side effects.
    always_comb begin
        bus.io_out = '0;
        if (hit) begin
            case (off)
                2'd0:    bus.io_out = DATA_W'(count);
                2'd1:    bus.io_out = rx_reg;
                2'd2:    bus.io_out = status;
                default: bus.io_out = {14'h0, loop, tx_en};
            endcase
        end
    end

    // FIFO storage carries no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.d_in;
    end

    // Stage p1: registered strobe plus all control state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_p1   <= 1'b0;
            off_p1  <= 2'd0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            tx_ovf  <= 1'b0;
            rx_full <= 1'b0;
            rx_reg  <= '0;
            tx_en   <= 1'b1;
            loop    <= 1'b0;
        end else begin
            wr_p1  <= wr;
            off_p1 <= off;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (push_req && tx_full)
                tx_ovf <= 1'b1;
            else if (stat_wr && bus.d_in[7])
                tx_ovf <= 1'b0;

            // A load needs rx_full low, so it can never collide with a
            // meaningful ack; a load simply wins.
            if (rx_load) begin
                rx_reg  <= rx_load_data;
                rx_full <= 1'b1;
            end else if (ack) begin
                rx_full <= 1'b0;
            end

            if (ctrl_wr) begin
                tx_en <= bus.d_in[0];
                loop  <= bus.d_in[1];
            end
        end
    end
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: directed testbench for io_port. Drives the CPU bus and the
// TX/RX streams through io_port_if and checks reads and stream outputs
// against hand-computed values.
module tb_io_port;
    localparam logic [15:0] BASE = 16'hFF00;

    // STATUS field values used to build expected words
    localparam logic [15:0] S_EMPTY = 16'h0010;
    localparam logic [15:0] S_FULL  = 16'h0020;
    localparam logic [15:0] S_RXF   = 16'h0040;
    localparam logic [15:0] S_OVF   = 16'h0080;
    localparam logic [15:0] S_TXEN  = 16'h0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    io_port_if bus();

    io_port #(.BASE(BASE), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One-cycle write strobe followed by one idle cycle
    task automatic io_wr(input logic [1:0] off, input logic [15:0] d);
        bus.a_in   = BASE | 16'(off);
        bus.d_in   = d;
        bus.wen_in = 1'b1;
        bus.iom_in = 1'b1;
        cyc();
        bus.wen_in = 1'b0;
        bus.iom_in = 1'b0;
        cyc();
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] off, input logic [15:0] exp);
        logic [15:0] v;
        bus.a_in   = BASE | 16'(off);
        bus.wen_in = 1'b0;
        bus.iom_in = 1'b1;
        #1;
        v = bus.io_out;
        bus.iom_in = 1'b0;
        check(tag, v, exp);
    endtask

    task automatic chk_sig(input string tag, input logic [15:0] exp);
        logic [15:0] v;
        #1;
        case (tag)
            "tx_valid": v = 16'(bus.tx_valid_out);
            "rx_ready": v = 16'(bus.rx_ready_out);
            default:    v = bus.tx_data_out;
        endcase
        check(tag, v, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_q [3];
        bus.a_in        = 16'h0;
        bus.d_in        = 16'h0;
        bus.wen_in      = 1'b0;
        bus.iom_in      = 1'b0;
        bus.tx_ready_in = 1'b0;
        bus.rx_data_in  = 16'h0;
        bus.rx_valid_in = 1'b0;

        // Reset
        cyc();
        cyc();
        chk_sig("tx_valid", 16'h0);
        chk_sig("rx_ready", 16'h0);
        chk_sig("tx_data", 16'h0);
        chk_rd("rst_status", 2'd2, S_EMPTY | S_TXEN);
        chk_rd("rst_ctrl", 2'd3, 16'h0001);
        chk_rd("rst_rxdata", 2'd1, 16'h0000);
        rst = 1'b0;
        chk_sig("rx_ready", 16'h1);
        bus.a_in   = 16'h1234;
        bus.iom_in = 1'b1;
        #1;
        check("miss_read", bus.io_out, 16'h0);
        bus.iom_in = 1'b0;
        cyc();

        // TX fill and overflow
        io_wr(2'd0, 16'h1111);
        io_wr(2'd0, 16'h2222);
        io_wr(2'd0, 16'h3333);
        io_wr(2'd0, 16'h4444);
        io_wr(2'd0, 16'h5555);
        chk_rd("fill_count", 2'd0, 16'h0004);
        chk_rd("fill_status", 2'd2, 16'h0004 | S_FULL | S_OVF | S_TXEN);
        chk_sig("tx_valid", 16'h1);
        bus.tx_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_sig("tx_data", 16'h1111 * 16'(i + 1));
            cyc();
        end
        bus.tx_ready_in = 1'b0;
        chk_sig("tx_valid", 16'h0);
        chk_rd("drain_count", 2'd0, 16'h0000);
        io_wr(2'd2, 16'h0080);
        chk_rd("ovf_clear", 2'd2, S_EMPTY | S_TXEN);

        // Held strobe
        bus.a_in   = BASE;
        bus.d_in   = 16'hABCD;
        bus.wen_in = 1'b1;
        bus.iom_in = 1'b1;
        repeat (5) cyc();
        bus.wen_in = 1'b0;
        bus.iom_in = 1'b0;
        chk_rd("held_count", 2'd0, 16'h0001);
        chk_sig("tx_data", 16'hABCD);
        bus.tx_ready_in = 1'b1;
        cyc();
        bus.tx_ready_in = 1'b0;
        chk_rd("held_drain", 2'd0, 16'h0000);

        // Push while full with a simultaneous pop
        io_wr(2'd0, 16'h0001);
        io_wr(2'd0, 16'h0002);
        io_wr(2'd0, 16'h0003);
        io_wr(2'd0, 16'h0004);
        bus.a_in        = BASE;
        bus.d_in        = 16'h9999;
        bus.wen_in      = 1'b1;
        bus.iom_in      = 1'b1;
        bus.tx_ready_in = 1'b1;
        cyc();
        bus.wen_in      = 1'b0;
        bus.iom_in      = 1'b0;
        bus.tx_ready_in = 1'b0;
        chk_rd("pp_status", 2'd2, 16'h0003 | S_OVF | S_TXEN);
        exp_q = '{16'h0002, 16'h0003, 16'h0004};
        bus.tx_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_sig("tx_data", exp_q[i]);
            cyc();
        end
        bus.tx_ready_in = 1'b0;
        chk_sig("tx_valid", 16'h0);
        io_wr(2'd2, 16'h0080);

        // RX handshake
        bus.rx_data_in  = 16'hBEEF;
        bus.rx_valid_in = 1'b1;
        chk_sig("rx_ready", 16'h1);
        cyc();
        bus.rx_data_in = 16'hCAFE;
        chk_sig("rx_ready", 16'h0);
        chk_rd("rx_status", 2'd2, S_EMPTY | S_RXF | S_TXEN);
        chk_rd("rx_first", 2'd1, 16'hBEEF);
        cyc();
        chk_rd("rx_holdoff", 2'd1, 16'hBEEF);
        io_wr(2'd1, 16'h0000);
        chk_rd("rx_second", 2'd1, 16'hCAFE);
        chk_sig("rx_ready", 16'h0);
        bus.rx_valid_in = 1'b0;
        io_wr(2'd1, 16'h0000);
        chk_sig("rx_ready", 16'h1);

        // Loopback
        io_wr(2'd3, 16'h0003);
        chk_rd("lb_ctrl", 2'd3, 16'h0003);
        chk_sig("rx_ready", 16'h0);
        io_wr(2'd0, 16'h0A0A);
        chk_sig("tx_valid", 16'h0);
        io_wr(2'd0, 16'h0B0B);
        chk_sig("tx_valid", 16'h0);
        chk_rd("lb_first", 2'd1, 16'h0A0A);
        chk_rd("lb_count", 2'd0, 16'h0001);
        bus.rx_data_in  = 16'hDEAD;
        bus.rx_valid_in = 1'b1;
        io_wr(2'd1, 16'h0000);
        bus.rx_valid_in = 1'b0;
        chk_rd("lb_second", 2'd1, 16'h0B0B);
        chk_rd("lb_status", 2'd2, S_EMPTY | S_RXF | S_TXEN);

        // Reset mid-operation with a strobe held across release
        io_wr(2'd3, 16'h0001);
        io_wr(2'd0, 16'h1234);
        chk_rd("pre_rst_count", 2'd0, 16'h0001);
        rst        = 1'b1;
        bus.a_in   = BASE;
        bus.d_in   = 16'h5678;
        bus.wen_in = 1'b1;
        bus.iom_in = 1'b1;
        cyc();
        chk_sig("tx_valid", 16'h0);
        chk_sig("rx_ready", 16'h0);
        rst = 1'b0;
        cyc();
        bus.wen_in = 1'b0;
        bus.iom_in = 1'b0;
        chk_rd("post_rst_status", 2'd2, 16'h0001 | S_TXEN);
        chk_sig("tx_data", 16'h5678);
        chk_rd("post_rst_rx", 2'd1, 16'h0000);
        chk_sig("rx_ready", 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
